// File: rtl/fifo_wr_feeder.sv
// fifo_wr_feeder: serialises ALU results (two bytes, low byte first) and
// register-file bytes (one byte) into the write port of an async FIFO.
// One message is in flight at a time. Any strobe that arrives while busy,
// and the RF byte in an ALU/RF collision, is discarded and flagged on DROP.
module fifo_wr_feeder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    W_CLK,
  input  logic                    W_RST,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  input  logic                    FULL,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    W_INC,
  output logic                    BUSY,
  output logic                    DROP,
  output logic [7:0]              TX_CNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    WR_RF = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    drop_q, drop_d;
  logic [7:0]              cnt_q, cnt_d;
  // Low through the first edge after reset release, so a strobe landing on
  // that edge is ignored rather than racing the reset deassertion.
  logic                    arm_q;

  logic alu_stb, rf_stb, xfer;

  assign alu_stb = ALU_VLD & arm_q;
  assign rf_stb  = RF_RD_VLD & arm_q;
  // A transfer happens on any edge where a message is pending and FIFO has room.
  assign xfer    = (state_q != IDLE) & ~FULL;

  // State register plus datapath registers, async active-low reset.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      wr_data_q <= '0;
      drop_q    <= 1'b0;
      cnt_q     <= '0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      arm_q     <= 1'b1;
    end
  end

  // Next-state, hold/byte selection and discard detection.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wr_data_d = wr_data_q;
    drop_d    = 1'b0;
    cnt_d     = cnt_q;

    if (xfer) cnt_d = cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (alu_stb) begin
          // ALU has priority; a simultaneous RF byte is lost.
          hold_d    = ALU_OUT;
          wr_data_d = ALU_OUT[DATA_WIDTH-1:0];
          state_d   = WR_LO;
          drop_d    = rf_stb;
        end else if (rf_stb) begin
          wr_data_d = RF_RD_DATA;
          state_d   = WR_RF;
        end
      end
      WR_LO: begin
        drop_d = alu_stb | rf_stb;
        if (!FULL) begin
          wr_data_d = hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = WR_HI;
        end
      end
      WR_HI, WR_RF: begin
        // Last byte keeps WR_DATA as-is; only the state returns to IDLE.
        drop_d = alu_stb | rf_stb;
        if (!FULL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign WR_DATA = wr_data_q;
  assign W_INC   = xfer;
  assign BUSY    = (state_q != IDLE);
  assign DROP    = drop_q;
  assign TX_CNT  = cnt_q;

endmodule

// File: tb/tb_fifo_wr_feeder.sv
// Directed bench for fifo_wr_feeder: each task drives one scenario and
// checks outputs 1ns after the rising edge against hand-computed values.
module tb_fifo_wr_feeder;

  localparam int DW = 8;

  logic          W_CLK = 1'b0;
  logic          W_RST;
  logic [2*DW-1:0] ALU_OUT;
  logic          ALU_VLD;
  logic [DW-1:0] RF_RD_DATA;
  logic          RF_RD_VLD;
  logic          FULL;
  logic [DW-1:0] WR_DATA;
  logic          W_INC, BUSY, DROP;
  logic [7:0]    TX_CNT;

  int pass_cnt = 0;
  int total    = 0;

  fifo_wr_feeder #(.DATA_WIDTH(DW)) dut (
    .W_CLK(W_CLK), .W_RST(W_RST),
    .ALU_OUT(ALU_OUT), .ALU_VLD(ALU_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
    .FULL(FULL),
    .WR_DATA(WR_DATA), .W_INC(W_INC), .BUSY(BUSY), .DROP(DROP), .TX_CNT(TX_CNT)
  );

  always #5 W_CLK = ~W_CLK;

  task automatic step();
    @(posedge W_CLK);
    #1;
  endtask

  task automatic test_reset();
    W_RST = 1'b0; ALU_OUT = '0; ALU_VLD = 0; RF_RD_DATA = '0; RF_RD_VLD = 0; FULL = 0;
    #2;
    total++; if (WR_DATA !== 8'h00) $display("FAIL rst_wr_data got %h exp 00", WR_DATA); else pass_cnt++;
    total++; if (W_INC !== 1'b0) $display("FAIL rst_w_inc got %b exp 0", W_INC); else pass_cnt++;
    total++; if (BUSY !== 1'b0) $display("FAIL rst_busy got %b exp 0", BUSY); else pass_cnt++;
    total++; if (DROP !== 1'b0) $display("FAIL rst_drop got %b exp 0", DROP); else pass_cnt++;
    total++; if (TX_CNT !== 8'd0) $display("FAIL rst_tx_cnt got %0d exp 0", TX_CNT); else pass_cnt++;
    step(); step();
    // Release reset together with a strobe: the release edge must ignore it.
    W_RST = 1'b1; ALU_VLD = 1; ALU_OUT = 16'hFFFF;
    step();
    ALU_VLD = 0;
    total++; if (BUSY !== 1'b0) $display("FAIL rel_strobe_busy got %b exp 0", BUSY); else pass_cnt++;
    total++; if (W_INC !== 1'b0) $display("FAIL rel_strobe_w_inc got %b exp 0", W_INC); else pass_cnt++;
    step();
    total++; if (TX_CNT !== 8'd0) $display("FAIL rel_strobe_cnt got %0d exp 0", TX_CNT); else pass_cnt++;
  endtask

  task automatic test_alu();
    ALU_OUT = 16'hA55A; ALU_VLD = 1;
    step();
    ALU_VLD = 0;
    total++; if (W_INC !== 1'b1) $display("FAIL alu_inc1 got %b exp 1", W_INC); else pass_cnt++;
    total++; if (WR_DATA !== 8'h5A) $display("FAIL alu_lo got %h exp 5a", WR_DATA); else pass_cnt++;
    total++; if (BUSY !== 1'b1) $display("FAIL alu_busy got %b exp 1", BUSY); else pass_cnt++;
    step();
    total++; if (W_INC !== 1'b1) $display("FAIL alu_inc2 got %b exp 1", W_INC); else pass_cnt++;
    total++; if (WR_DATA !== 8'hA5) $display("FAIL alu_hi got %h exp a5", WR_DATA); else pass_cnt++;
    step();
    total++; if (BUSY !== 1'b0) $display("FAIL alu_busy_end got %b exp 0", BUSY); else pass_cnt++;
    total++; if (W_INC !== 1'b0) $display("FAIL alu_inc_end got %b exp 0", W_INC); else pass_cnt++;
    total++; if (TX_CNT !== 8'd2) $display("FAIL alu_cnt got %0d exp 2", TX_CNT); else pass_cnt++;
    total++; if (WR_DATA !== 8'hA5) $display("FAIL alu_hold_last got %h exp a5", WR_DATA); else pass_cnt++;
  endtask

  task automatic test_rf();
    RF_RD_DATA = 8'h3C; RF_RD_VLD = 1;
    step();
    RF_RD_VLD = 0;
    total++; if (W_INC !== 1'b1) $display("FAIL rf_inc got %b exp 1", W_INC); else pass_cnt++;
    total++; if (WR_DATA !== 8'h3C) $display("FAIL rf_data got %h exp 3c", WR_DATA); else pass_cnt++;
    step();
    total++; if (W_INC !== 1'b0) $display("FAIL rf_inc_end got %b exp 0", W_INC); else pass_cnt++;
    total++; if (TX_CNT !== 8'd3) $display("FAIL rf_cnt got %0d exp 3", TX_CNT); else pass_cnt++;
  endtask

  task automatic test_stall();
    int bad = 0;
    ALU_OUT = 16'h1234; ALU_VLD = 1; FULL = 1;
    step();
    ALU_VLD = 0;
    for (int i = 0; i < 5; i++) begin
      if (W_INC !== 1'b0 || WR_DATA !== 8'h34 || BUSY !== 1'b1) bad++;
      if (i < 4) step();
    end
    total++; if (bad != 0) $display("FAIL stall_hold got %0d bad cycles exp 0", bad); else pass_cnt++;
    total++; if (TX_CNT !== 8'd3) $display("FAIL stall_cnt got %0d exp 3", TX_CNT); else pass_cnt++;
    FULL = 0;
    #1;
    total++; if (W_INC !== 1'b1) $display("FAIL stall_rel_inc got %b exp 1", W_INC); else pass_cnt++;
    total++; if (WR_DATA !== 8'h34) $display("FAIL stall_lo got %h exp 34", WR_DATA); else pass_cnt++;
    step();
    total++; if (WR_DATA !== 8'h12) $display("FAIL stall_hi got %h exp 12", WR_DATA); else pass_cnt++;
    // Stall mid-message on the high byte too.
    FULL = 1;
    step();
    total++; if (BUSY !== 1'b1 || WR_DATA !== 8'h12) $display("FAIL stall_hi_hold got busy=%b data=%h exp 1/12", BUSY, WR_DATA); else pass_cnt++;
    FULL = 0;
    step();
    total++; if (BUSY !== 1'b0) $display("FAIL stall_end got %b exp 0", BUSY); else pass_cnt++;
    total++; if (TX_CNT !== 8'd5) $display("FAIL stall_cnt_end got %0d exp 5", TX_CNT); else pass_cnt++;
  endtask

  task automatic test_collision();
    ALU_OUT = 16'hBEEF; ALU_VLD = 1; RF_RD_DATA = 8'h77; RF_RD_VLD = 1;
    step();
    ALU_VLD = 0; RF_RD_VLD = 0;
    total++; if (DROP !== 1'b1) $display("FAIL col_drop got %b exp 1", DROP); else pass_cnt++;
    total++; if (WR_DATA !== 8'hEF) $display("FAIL col_lo got %h exp ef", WR_DATA); else pass_cnt++;
    step();
    total++; if (DROP !== 1'b0) $display("FAIL col_drop_pulse got %b exp 0", DROP); else pass_cnt++;
    total++; if (WR_DATA !== 8'hBE) $display("FAIL col_hi got %h exp be", WR_DATA); else pass_cnt++;
    RF_RD_VLD = 1;  // arrives in WR_HI
    step();
    RF_RD_VLD = 0;
    total++; if (DROP !== 1'b1) $display("FAIL busy_drop got %b exp 1", DROP); else pass_cnt++;
    total++; if (BUSY !== 1'b0 || W_INC !== 1'b0) $display("FAIL busy_drop_idle got busy=%b inc=%b exp 0/0", BUSY, W_INC); else pass_cnt++;
    step();
    total++; if (DROP !== 1'b0) $display("FAIL busy_drop_pulse got %b exp 0", DROP); else pass_cnt++;
    total++; if (TX_CNT !== 8'd7) $display("FAIL col_cnt got %0d exp 7", TX_CNT); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    ALU_OUT = 16'h5678; ALU_VLD = 1;
    step();
    ALU_VLD = 0;
    step();
    total++; if (WR_DATA !== 8'h56 || BUSY !== 1'b1) $display("FAIL rm_in_hi got data=%h busy=%b exp 56/1", WR_DATA, BUSY); else pass_cnt++;
    W_RST = 0;
    #1;
    total++; if (WR_DATA !== 8'h00 || W_INC !== 1'b0 || BUSY !== 1'b0 || DROP !== 1'b0 || TX_CNT !== 8'd0)
      $display("FAIL rm_async got data=%h inc=%b busy=%b drop=%b cnt=%0d exp all 0", WR_DATA, W_INC, BUSY, DROP, TX_CNT);
    else pass_cnt++;
    step();
    W_RST = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (W_INC !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL rm_no_inc got %0d bad cycles exp 0", bad); else pass_cnt++;
  endtask

  task automatic test_back_to_back_wrap();
    int incs = 0;
    int drops = 0;
    for (int m = 0; m < 128; m++) begin
      ALU_OUT = 16'(m * 257 + 1); ALU_VLD = 1;
      step();
      ALU_VLD = 0;
      for (int k = 0; k < 2; k++) begin
        if (W_INC === 1'b1) incs++;
        if (DROP === 1'b1) drops++;
        step();
      end
      if (m == 126) begin
        total++; if (TX_CNT !== 8'd254) $display("FAIL wrap_pre got %0d exp 254", TX_CNT); else pass_cnt++;
      end
    end
    total++; if (incs != 256) $display("FAIL wrap_incs got %0d exp 256", incs); else pass_cnt++;
    total++; if (drops != 0) $display("FAIL wrap_drops got %0d exp 0", drops); else pass_cnt++;
    total++; if (TX_CNT !== 8'd0) $display("FAIL wrap_cnt got %0d exp 0", TX_CNT); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_rf();
    test_stall();
    test_collision();
    test_reset_mid();
    test_back_to_back_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_wr_feeder.md
FIFO_WR_FEEDER -- requirements
Module: fifo_wr_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, FIFO byte width.
REQ-002 SHALL have port W_CLK  input  1  write-domain clock; all state updates on rising edge.
REQ-003 SHALL have port W_RST  input  1  reset W_RST, asynchronous, active-low; clock W_CLK.
REQ-004 SHALL have port ALU_OUT  input  2*DATA_WIDTH  ALU result to transmit.
REQ-005 SHALL have port ALU_VLD  input  1  single-cycle strobe qualifying ALU_OUT.
REQ-006 SHALL have port RF_RD_DATA  input  DATA_WIDTH  register-file read data to transmit.
REQ-007 SHALL have port RF_RD_VLD  input  1  single-cycle strobe qualifying RF_RD_DATA.
REQ-008 SHALL have port FULL  input  1  FIFO full flag from the FIFO write-side controller.
REQ-009 SHALL have port WR_DATA  output  DATA_WIDTH  byte presented to FIFO memory, registered.
REQ-010 SHALL have port W_INC  output  1  FIFO write request.
REQ-011 SHALL have port BUSY  output  1  high while a message is pending.
REQ-012 SHALL have port DROP  output  1  one-cycle registered pulse: a strobe was discarded.
REQ-013 SHALL have port TX_CNT  output  8  count of bytes accepted by the FIFO.

Function
REQ-014 SHALL implement FSM states IDLE, WR_LO, WR_HI, WR_RF.
REQ-015 A "transfer" SHALL be defined as a W_CLK edge where W_INC=1 (which implies FULL=0).
REQ-016 W_INC SHALL equal (state != IDLE) AND NOT FULL, decoded from registered state and FULL only.
REQ-017 IDLE, ALU_VLD=1: capture ALU_OUT into 2*DATA_WIDTH hold register; WR_DATA <= ALU_OUT low byte; next WR_LO.
REQ-018 IDLE, ALU_VLD=0, RF_RD_VLD=1: WR_DATA <= RF_RD_DATA; next WR_RF.
REQ-019 IDLE, both strobes high: ALU wins; RF byte discarded; DROP=1 the following cycle.
REQ-020 WR_LO on transfer: WR_DATA <= hold high byte; next WR_HI.
REQ-021 WR_HI or WR_RF on transfer: next IDLE; WR_DATA unchanged.
REQ-022 Any non-IDLE state with FULL=1: state, hold register, WR_DATA all held, no cycle limit.
REQ-023 Any strobe arriving while state != IDLE SHALL be discarded, DROP=1 the following cycle; in-flight message unaffected.
REQ-024 DROP SHALL be a single-cycle pulse per discarding cycle, not sticky.
REQ-025 Latency: strobe at edge N -> W_INC high in cycle N+1 if FULL=0.
REQ-026 ALU message SHALL produce exactly two transfers, low byte first; RF message exactly one.
REQ-027 Back-to-back: strobe accepted in IDLE in the same cycle the previous message's last transfer returns state to IDLE only if state is already IDLE; no overlap of messages.
REQ-028 BUSY SHALL equal (state != IDLE).
REQ-029 TX_CNT SHALL increment by 1 per transfer, wrapping 255 -> 0.
REQ-030 FULL toggling mid-message SHALL only stall; byte order and count preserved.

Reset
REQ-031 W_RST=0 SHALL force asynchronously: state IDLE, hold register 0, WR_DATA 0, DROP 0, TX_CNT 0; hence W_INC 0, BUSY 0.
REQ-032 Reset asserted mid-message SHALL abandon remaining bytes; no W_INC after reset release until a new strobe.
REQ-033 Strobes coincident with the reset-release edge SHALL be ignored.

Verification
REQ-034 FULL=0, ALU_VLD with ALU_OUT=0xA55A -> W_INC cycles N+1, N+2 with WR_DATA 0x5A then 0xA5; TX_CNT=2; BUSY low at N+3.
REQ-035 FULL=0, RF_RD_VLD with 0x3C -> one W_INC with WR_DATA 0x3C; TX_CNT +1.
REQ-036 ALU_VLD (0x1234) while FULL=1 for 5 cycles, then 0 -> W_INC 0 during stall, WR_DATA held 0x34, then 0x34, 0x12 written.
REQ-037 ALU_VLD and RF_RD_VLD same cycle -> only 0x?? ALU bytes written, DROP pulse 1 cycle; RF_RD_VLD during WR_HI -> DROP pulse, no extra transfer.
REQ-038 Reset asserted in WR_HI -> all outputs 0 immediately; after release no W_INC without new strobe.
REQ-039 128 ALU messages, FULL=0 -> TX_CNT wraps to 0 after 256 transfers.
